// File: rtl/cvxif_offload_pkg.sv
// Shared types for the core-side CV-X-IF offload unit: X interface structs, slot table
// entries, the issue hold register and the exception cause constant.
package cvxif_offload_pkg;

    localparam int XLEN          = 32;
    localparam int TRANS_ID_BITS = 3;
    localparam int X_ID_WIDTH    = 4;
    localparam int X_NUM_RS      = 2;

    typedef struct packed {
        int unsigned XLEN;
        int unsigned TRANS_ID_BITS;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 32, TRANS_ID_BITS: 3};

    localparam logic [XLEN-1:0] EXC_ILLEGAL_INSTR = XLEN'(2);

    typedef logic [X_ID_WIDTH-1:0] slot_idx_t;

    typedef struct packed {
        logic                     busy;
        logic [TRANS_ID_BITS-1:0] trans_id;
    } slot_entry_t;

    typedef struct packed {
        logic [31:0]              instr;
        logic [XLEN-1:0]          rs1;
        logic [XLEN-1:0]          rs2;
        logic [TRANS_ID_BITS-1:0] trans_id;
        slot_idx_t                slot;
    } hold_t;

    typedef struct packed {
        logic [31:0]                      instr;
        logic [X_ID_WIDTH-1:0]            id;
        logic [X_NUM_RS-1:0][XLEN-1:0]    rs;
        logic [X_NUM_RS-1:0]              rs_valid;
    } x_issue_req_t;

    typedef struct packed {
        logic            exc;
        logic [XLEN-1:0] rdata;
    } x_mem_resp_t;

    typedef struct packed {
        logic         x_compressed_valid;
        logic         x_issue_valid;
        x_issue_req_t x_issue_req;
        logic         x_commit_valid;
        logic         x_mem_ready;
        logic         x_mem_resp_valid;
        x_mem_resp_t  x_mem_resp;
        logic         x_result_ready;
    } cvxif_req_t;

    typedef struct packed {
        logic accept;
    } x_issue_resp_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [XLEN-1:0]       data;
        logic                  we;
    } x_result_t;

    typedef struct packed {
        logic          x_issue_ready;
        x_issue_resp_t x_issue_resp;
        logic          x_result_valid;
        x_result_t     x_result;
    } cvxif_resp_t;

endpackage

// File: rtl/cvxif_offload_unit_lzc.sv
// Lowest-set-bit finder used to pick the lowest-index free slot.
module cvxif_offload_unit_lzc #(
    parameter int Width = 4,
    parameter int IdxW  = (Width > 1) ? $clog2(Width) : 1
) (
    input  logic [Width-1:0] i_vec,
    output logic [IdxW-1:0]  o_idx,
    output logic             o_empty
);

    // Scan from the top so the lowest set bit is the last one to win.
    always_comb begin
        o_idx = '0;
        for (int i = Width - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = IdxW'(i);
            end
        end
    end

    assign o_empty = ~|i_vec;

endmodule

// File: rtl/cvxif_offload_unit.sv
// Core-side CV-X-IF initiator: holds one offload request, tracks accepted instructions in a
// slot table indexed by X id, and returns results or illegal-instruction exceptions to the core.
module cvxif_offload_unit
    import cvxif_offload_pkg::*;
#(
    parameter cva6_cfg_t CVA6Cfg      = cva6_cfg_empty,
    parameter int        NrSlots      = 4,
    parameter int        TransIdWidth = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      issue_valid_i,
    output logic                      issue_ready_o,
    input  logic [31:0]               instr_i,
    input  logic [CVA6Cfg.XLEN-1:0]   rs1_i,
    input  logic [CVA6Cfg.XLEN-1:0]   rs2_i,
    input  logic [TransIdWidth-1:0]   trans_id_i,
    output logic                      result_valid_o,
    output logic [TransIdWidth-1:0]   result_trans_id_o,
    output logic [CVA6Cfg.XLEN-1:0]   result_data_o,
    output logic                      result_we_o,
    output logic                      exception_valid_o,
    output logic [CVA6Cfg.XLEN-1:0]   exception_tval_o,
    output logic                      id_error_o,
    output cvxif_req_t                cvxif_req_o,
    input  cvxif_resp_t               cvxif_resp_i
);

    localparam int unsigned           Xlen     = CVA6Cfg.XLEN;
    localparam int                    SlotW    = (NrSlots > 1) ? $clog2(NrSlots) : 1;
    localparam logic [X_ID_WIDTH:0]   NrSlotsX = (X_ID_WIDTH + 1)'(NrSlots);

    slot_entry_t              r_slots [NrSlots];
    hold_t                    r_hold;
    logic                     r_hold_valid;
    logic                     r_exc_valid;
    logic [TransIdWidth-1:0]  r_exc_trans_id;
    logic [Xlen-1:0]          r_exc_tval;

    logic                     r_res_valid;
    logic [TransIdWidth-1:0]  r_res_trans_id;
    logic [Xlen-1:0]          r_res_data;
    logic                     r_res_we;
    logic                     r_exc_out_valid;
    logic [Xlen-1:0]          r_exc_out_tval;
    logic                     r_id_error;

    logic [NrSlots-1:0]       w_free;
    logic [SlotW-1:0]         w_free_idx;
    logic                     w_none_free;
    logic                     w_issue_ready;
    logic                     w_core_acc;
    logic                     w_x_xfer;
    logic                     w_x_acc;
    logic                     w_x_rej;
    logic [X_ID_WIDTH-1:0]    w_res_id;
    logic                     w_res_in_range;
    logic [SlotW-1:0]         w_res_slot;
    logic                     w_res_hit;

    always_comb begin
        w_free = '0;
        for (int i = 0; i < NrSlots; i++) begin
            w_free[i] = !r_slots[i].busy;
        end
    end

    cvxif_offload_unit_lzc #(
        .Width (NrSlots),
        .IdxW  (SlotW)
    ) u_lzc (
        .i_vec   (w_free),
        .o_idx   (w_free_idx),
        .o_empty (w_none_free)
    );

    // Ready is masked during reset so nothing is captured while state is being cleared.
    assign w_issue_ready  = !rst_i && !r_hold_valid && !r_exc_valid && !w_none_free;
    assign w_core_acc     = issue_valid_i && w_issue_ready;
    assign w_x_xfer       = r_hold_valid && cvxif_resp_i.x_issue_ready;
    assign w_x_acc        = w_x_xfer && cvxif_resp_i.x_issue_resp.accept;
    assign w_x_rej        = w_x_xfer && !cvxif_resp_i.x_issue_resp.accept;

    assign w_res_id       = cvxif_resp_i.x_result.id;
    assign w_res_in_range = {1'b0, w_res_id} < NrSlotsX;
    assign w_res_slot     = w_res_id[SlotW-1:0];
    assign w_res_hit      = cvxif_resp_i.x_result_valid && w_res_in_range && r_slots[w_res_slot].busy;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hold_valid <= 1'b0;
            r_hold       <= '0;
        end else if (w_core_acc) begin
            r_hold_valid <= 1'b1;
            r_hold       <= '{instr:    instr_i,
                              rs1:      rs1_i,
                              rs2:      rs2_i,
                              trans_id: trans_id_i,
                              slot:     slot_idx_t'(w_free_idx)};
        end else if (w_x_xfer) begin
            r_hold_valid <= 1'b0;
        end
    end

    // The held slot stays free until accepted, but only one hold exists, so no other
    // request can claim it; a result for it in the meantime is an id error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NrSlots; i++) begin
                r_slots[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NrSlots; i++) begin
                if (w_x_acc && (r_hold.slot == slot_idx_t'(i))) begin
                    r_slots[i] <= '{busy: 1'b1, trans_id: r_hold.trans_id};
                end else if (w_res_hit && (w_res_slot == SlotW'(i))) begin
                    r_slots[i].busy <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_exc_valid    <= 1'b0;
            r_exc_trans_id <= '0;
            r_exc_tval     <= '0;
        end else if (w_x_rej) begin
            r_exc_valid    <= 1'b1;
            r_exc_trans_id <= r_hold.trans_id;
            r_exc_tval     <= Xlen'(r_hold.instr);
        end else if (r_exc_valid && !cvxif_resp_i.x_result_valid) begin
            r_exc_valid    <= 1'b0;
        end
    end

    // Writeback arbitration: an X result always wins; the exception waits for an idle cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_res_valid     <= 1'b0;
            r_res_trans_id  <= '0;
            r_res_data      <= '0;
            r_res_we        <= 1'b0;
            r_exc_out_valid <= 1'b0;
            r_exc_out_tval  <= '0;
            r_id_error      <= 1'b0;
        end else begin
            r_res_valid     <= 1'b0;
            r_res_trans_id  <= '0;
            r_res_data      <= '0;
            r_res_we        <= 1'b0;
            r_exc_out_valid <= 1'b0;
            r_exc_out_tval  <= '0;
            r_id_error      <= 1'b0;
            if (cvxif_resp_i.x_result_valid) begin
                if (w_res_hit) begin
                    r_res_valid    <= 1'b1;
                    r_res_trans_id <= r_slots[w_res_slot].trans_id;
                    r_res_data     <= cvxif_resp_i.x_result.data;
                    r_res_we       <= cvxif_resp_i.x_result.we;
                end else begin
                    r_id_error     <= 1'b1;
                end
            end else if (r_exc_valid) begin
                r_res_valid     <= 1'b1;
                r_res_trans_id  <= r_exc_trans_id;
                r_exc_out_valid <= 1'b1;
                r_exc_out_tval  <= r_exc_tval;
            end
        end
    end

    always_comb begin
        cvxif_req_o                      = '0;
        cvxif_req_o.x_issue_valid        = r_hold_valid;
        cvxif_req_o.x_issue_req.instr    = r_hold.instr;
        cvxif_req_o.x_issue_req.id       = r_hold.slot;
        cvxif_req_o.x_issue_req.rs[0]    = r_hold.rs1;
        cvxif_req_o.x_issue_req.rs[1]    = r_hold.rs2;
        cvxif_req_o.x_issue_req.rs_valid = {X_NUM_RS{r_hold_valid}};
        cvxif_req_o.x_result_ready       = 1'b1;
    end

    assign issue_ready_o     = w_issue_ready;
    assign result_valid_o    = r_res_valid;
    assign result_trans_id_o = r_res_trans_id;
    assign result_data_o     = r_res_data;
    assign result_we_o       = r_res_we;
    assign exception_valid_o = r_exc_out_valid;
    assign exception_tval_o  = r_exc_out_tval;
    assign id_error_o        = r_id_error;

endmodule

// File: tb/tb_cvxif_offload_unit.sv
// Directed bench for cvxif_offload_unit with a queue-based scoreboard on the writeback port.
module tb_cvxif_offload_unit;
    import cvxif_offload_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [31:0] instr_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic [2:0]  trans_id_i;
    logic        result_valid_o;
    logic [2:0]  result_trans_id_o;
    logic [31:0] result_data_o;
    logic        result_we_o;
    logic        exception_valid_o;
    logic [31:0] exception_tval_o;
    logic        id_error_o;
    cvxif_req_t  req;
    cvxif_resp_t resp;

    always #5 clk_i = ~clk_i;

    cvxif_offload_unit dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .issue_valid_i     (issue_valid_i),
        .issue_ready_o     (issue_ready_o),
        .instr_i           (instr_i),
        .rs1_i             (rs1_i),
        .rs2_i             (rs2_i),
        .trans_id_i        (trans_id_i),
        .result_valid_o    (result_valid_o),
        .result_trans_id_o (result_trans_id_o),
        .result_data_o     (result_data_o),
        .result_we_o       (result_we_o),
        .exception_valid_o (exception_valid_o),
        .exception_tval_o  (exception_tval_o),
        .id_error_o        (id_error_o),
        .cvxif_req_o       (req),
        .cvxif_resp_i      (resp)
    );

    localparam logic [1:0] K_WB = 2'd0, K_EXC = 2'd1, K_IDERR = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [2:0]  tid;
        logic [31:0] data;
        logic        we;
        logic [31:0] tval;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic void exp_wb(input logic [2:0] tid, input logic [31:0] data, input logic we);
        sb_q.push_back('{kind: K_WB, tid: tid, data: data, we: we, tval: 32'h0});
    endfunction

    function automatic void exp_exc(input logic [2:0] tid, input logic [31:0] tval);
        sb_q.push_back('{kind: K_EXC, tid: tid, data: 32'h0, we: 1'b0, tval: tval});
    endfunction

    function automatic void exp_iderr();
        sb_q.push_back('{kind: K_IDERR, tid: 3'd0, data: 32'h0, we: 1'b0, tval: 32'h0});
    endfunction

    exp_t       mon_e;
    logic [1:0] mon_k;

    always @(negedge clk_i) begin
        if (!rst_i && (result_valid_o || id_error_o)) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_output", 64'({result_valid_o, id_error_o}), 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                mon_k = id_error_o ? K_IDERR : (exception_valid_o ? K_EXC : K_WB);
                chk("event_kind", 64'(mon_k), 64'(mon_e.kind));
                chk("result_valid", 64'(result_valid_o), 64'(mon_e.kind != K_IDERR));
                if (mon_e.kind != K_IDERR) begin
                    chk("result_trans_id", 64'(result_trans_id_o), 64'(mon_e.tid));
                    chk("result_we", 64'(result_we_o), 64'(mon_e.we));
                end
                if (mon_e.kind == K_WB) chk("result_data", 64'(result_data_o), 64'(mon_e.data));
                if (mon_e.kind == K_EXC) chk("exception_tval", 64'(exception_tval_o), 64'(mon_e.tval));
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic core_issue(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                              input logic [2:0] tid);
        int n = 0;
        while (!issue_ready_o && n < 20) begin
            tick();
            n++;
        end
        chk("issue_ready_wait", 64'(issue_ready_o), 64'd1);
        issue_valid_i = 1'b1;
        instr_i       = instr;
        rs1_i         = a;
        rs2_i         = b;
        trans_id_i    = tid;
        tick();
        issue_valid_i = 1'b0;
    endtask

    task automatic x_respond(input logic acc, input logic [3:0] id, input logic [31:0] instr,
                             input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (!req.x_issue_valid && n < 20) begin
            tick();
            n++;
        end
        chk("x_issue_valid_wait", 64'(req.x_issue_valid), 64'd1);
        chk("x_req_id", 64'(req.x_issue_req.id), 64'(id));
        chk("x_req_instr", 64'(req.x_issue_req.instr), 64'(instr));
        chk("x_req_rs1", 64'(req.x_issue_req.rs[0]), 64'(a));
        chk("x_req_rs2", 64'(req.x_issue_req.rs[1]), 64'(b));
        chk("x_req_rs_valid", 64'(req.x_issue_req.rs_valid), 64'd3);
        resp.x_issue_ready       = 1'b1;
        resp.x_issue_resp.accept = acc;
        tick();
        resp.x_issue_ready       = 1'b0;
        resp.x_issue_resp.accept = 1'b0;
    endtask

    task automatic x_result(input logic [3:0] id, input logic [31:0] data, input logic we);
        resp.x_result_valid = 1'b1;
        resp.x_result.id    = id;
        resp.x_result.data  = data;
        resp.x_result.we    = we;
        tick();
        resp.x_result_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        int ooo [4] = '{2, 0, 3, 1};
        int n;
        rst_i         = 1'b1;
        issue_valid_i = 1'b0;
        instr_i       = '0;
        rs1_i         = '0;
        rs2_i         = '0;
        trans_id_i    = '0;
        resp          = '0;
        repeat (3) tick();
        chk("rst_issue_ready", 64'(issue_ready_o), 64'd0);
        chk("rst_x_issue_valid", 64'(req.x_issue_valid), 64'd0);
        chk("rst_result_valid", 64'(result_valid_o), 64'd0);
        chk("rst_id_error", 64'(id_error_o), 64'd0);
        chk("rst_x_result_ready", 64'(req.x_result_ready), 64'd1);
        rst_i = 1'b0;
        tick();
        chk("idle_issue_ready", 64'(issue_ready_o), 64'd1);

        // Accept path: 5 + 7 computed by the responder as 12.
        core_issue(32'h0072_850B, 32'd5, 32'd7, 3'd2);
        x_respond(1'b1, 4'd0, 32'h0072_850B, 32'd5, 32'd7);
        exp_wb(3'd2, 32'd12, 1'b1);
        x_result(4'd0, 32'd12, 1'b1);

        // Backpressure: request must hold steady for three refused cycles.
        core_issue(32'h00A5_850B, 32'h11, 32'h22, 3'd3);
        for (int i = 0; i < 3; i++) begin
            chk("bp_x_issue_valid", 64'(req.x_issue_valid), 64'd1);
            chk("bp_issue_ready", 64'(issue_ready_o), 64'd0);
            chk("bp_req_instr", 64'(req.x_issue_req.instr), 64'h00A5_850B);
            chk("bp_req_rs1", 64'(req.x_issue_req.rs[0]), 64'h11);
            tick();
        end
        x_respond(1'b1, 4'd0, 32'h00A5_850B, 32'h11, 32'h22);
        chk("bp_single_transfer", 64'(req.x_issue_valid), 64'd0);
        exp_wb(3'd3, 32'h33, 1'b0);
        x_result(4'd0, 32'h33, 1'b0);

        // Reject: exception with tval = instruction, no slot consumed.
        core_issue(32'h0000_007F, 32'h1, 32'h2, 3'd1);
        exp_exc(3'd1, 32'h0000_007F);
        x_respond(1'b0, 4'd0, 32'h0000_007F, 32'h1, 32'h2);
        chk("rej_issue_ready_blocked", 64'(issue_ready_o), 64'd0);

        // Collision: result arrives the cycle after a reject; result goes first.
        core_issue(32'h0001_000B, 32'h3, 32'h4, 3'd4);
        x_respond(1'b1, 4'd0, 32'h0001_000B, 32'h3, 32'h4);
        core_issue(32'h0000_007F, 32'h0, 32'h0, 3'd6);
        exp_wb(3'd4, 32'h44, 1'b1);
        exp_exc(3'd6, 32'h0000_007F);
        x_respond(1'b0, 4'd1, 32'h0000_007F, 32'h0, 32'h0);
        x_result(4'd0, 32'h44, 1'b1);

        // Full table, then out-of-order completion.
        for (int k = 0; k < 4; k++) begin
            core_issue(32'h0000_100B + 32'(k), 32'(k), 32'(k + 10), 3'(k));
            x_respond(1'b1, 4'(k), 32'h0000_100B + 32'(k), 32'(k), 32'(k + 10));
        end
        chk("full_issue_ready", 64'(issue_ready_o), 64'd0);
        issue_valid_i = 1'b1;
        tick();
        chk("full_no_capture_1", 64'(req.x_issue_valid), 64'd0);
        tick();
        chk("full_no_capture_2", 64'(req.x_issue_valid), 64'd0);
        issue_valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_wb(3'(ooo[k]), 32'hA0 + 32'(ooo[k]), 1'b1);
            x_result(4'(ooo[k]), 32'hA0 + 32'(ooo[k]), 1'b1);
        end

        // Bad ids: free slot and out-of-range slot.
        exp_iderr();
        x_result(4'd3, 32'hDEAD, 1'b1);
        tick();
        exp_iderr();
        x_result(4'd9, 32'hBEEF, 1'b1);
        tick();
        chk("after_bad_id_issue_ready", 64'(issue_ready_o), 64'd1);

        // Reset mid-flight: one slot busy, one request held.
        core_issue(32'h0002_000B, 32'h5, 32'h6, 3'd5);
        x_respond(1'b1, 4'd0, 32'h0002_000B, 32'h5, 32'h6);
        core_issue(32'h0003_000B, 32'h7, 32'h8, 3'd6);
        chk("pre_rst_x_issue_valid", 64'(req.x_issue_valid), 64'd1);
        rst_i = 1'b1;
        tick();
        chk("mid_rst_x_issue_valid", 64'(req.x_issue_valid), 64'd0);
        chk("mid_rst_issue_ready", 64'(issue_ready_o), 64'd0);
        chk("mid_rst_result_valid", 64'(result_valid_o), 64'd0);
        chk("mid_rst_exception", 64'(exception_valid_o), 64'd0);
        chk("mid_rst_id_error", 64'(id_error_o), 64'd0);
        rst_i = 1'b0;
        tick();
        chk("post_rst_issue_ready", 64'(issue_ready_o), 64'd1);
        chk("post_rst_x_issue_valid", 64'(req.x_issue_valid), 64'd0);
        exp_iderr();
        x_result(4'd0, 32'h55, 1'b1);

        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        tick();
        chk("scoreboard_drain", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
